// File: rtl/north_buffer_feeder_pkg.sv
// Shared types for the north-buffer feeder: FSM state encoding and output FIFO depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package north_buffer_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_t;

    // Output FIFO entries; read issue is throttled against this.
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/north_buffer_feeder_fifo2_tagged.sv
// Two-entry FIFO holding one buffer word plus its end-of-pass / end-of-stream tags.
// Latency: push visible at the output the cycle after the push edge.
// Backpressure: pop only when non-empty; the caller guarantees no push into a full FIFO without a pop.
//
// Ports: clk/rst_n; push, push_data, push_last, push_fin (write side);
//        pop (read side); vld, dat, last, fin (head entry); count (occupancy 0..2).
module fifo2_tagged
    import north_buffer_feeder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             push_fin,
    input  logic             pop,
    output logic             vld,
    output logic [WIDTH-1:0] dat,
    output logic             last,
    output logic             fin,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem_dat;
    logic [1:0]            mem_last;
    logic [1:0]            mem_fin;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;
    logic                  pop_ok;

    assign pop_ok = pop && (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dat  <= '0;
            mem_last <= '0;
            mem_fin  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            // When full, push only ever coincides with pop, so overwriting the
            // head slot on the same edge is safe.
            if (push) begin
                mem_dat[wr_ptr]  <= push_data;
                mem_last[wr_ptr] <= push_last;
                mem_fin[wr_ptr]  <= push_fin;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign vld   = (cnt != 2'd0);
    assign dat   = mem_dat[rd_ptr];
    assign last  = vld & mem_last[rd_ptr];
    assign fin   = vld & mem_fin[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/north_buffer_feeder.sv
// Replays the north buffer num_passes times as a valid/ready word stream, tagging end of pass and end of stream.
// Latency: start sampled at edge T0 -> first rd_en in T1 -> first out_valid in T3; one beat per cycle thereafter.
// Backpressure: reads are only issued while the 2-entry output FIFO plus the in-flight read has room, so stalls never drop data.
//
// Ports: clk, rst_n; start/num_passes (command); busy/done (status);
//        rd_en/rd_addr/rd_dout (north buffer port B, 1-cycle read latency);
//        out_valid/out_ready/out_data/out_last/out_final (downstream stream).
module north_buffer_feeder
    import north_buffer_feeder_pkg::*;
#(
    parameter int MODULE_WIDTH = 32,
    parameter int TOTAL_DEPTH  = 16,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_DEPTH),
    parameter int PASS_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PASS_W-1:0]       num_passes,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [MODULE_WIDTH-1:0] rd_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MODULE_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    out_final
);

    feeder_state_t         state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [PASS_W-1:0]     pass_q;
    logic [PASS_W-1:0]     passes_q;
    logic                  infl_vld;
    logic                  infl_last;
    logic                  infl_fin;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  room;
    logic                  issue;
    logic                  addr_at_end;
    logic                  pass_at_end;

    assign pop         = out_valid & out_ready;
    assign addr_at_end = (addr_q == ADDR_WIDTH'(TOTAL_DEPTH - 1));
    assign pass_at_end = (pass_q == passes_q - PASS_W'(1));

    // Words already committed (queued + the read whose data lands next edge),
    // less the one leaving this cycle, must leave a free slot for a new read.
    // Compared as count+inflight < depth+pop to stay unsigned.
    assign room  = ({1'b0, fifo_count} + {2'b00, infl_vld}) < (3'(FIFO_DEPTH) + {2'b00, pop});
    assign issue = (state == ST_STREAM) && room;

    assign rd_en   = issue;
    assign rd_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_q    <= '0;
            pass_q    <= '0;
            passes_q  <= '0;
            infl_vld  <= 1'b0;
            infl_last <= 1'b0;
            infl_fin  <= 1'b0;
        end else begin
            done <= 1'b0;

            // Tags ride with the read so the FIFO entry knows its position
            // without any downstream counting.
            infl_vld  <= issue;
            infl_last <= issue & addr_at_end;
            infl_fin  <= issue & addr_at_end & pass_at_end;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_passes == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ST_STREAM;
                            busy     <= 1'b1;
                            passes_q <= num_passes;
                            pass_q   <= '0;
                            addr_q   <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        if (addr_at_end) begin
                            addr_q <= '0;
                            pass_q <= pass_q + PASS_W'(1);
                            if (pass_at_end) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_final) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo2_tagged #(
        .WIDTH (MODULE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_vld),
        .push_data (rd_dout),
        .push_last (infl_last),
        .push_fin  (infl_fin),
        .pop       (pop),
        .vld       (out_valid),
        .dat       (out_data),
        .last      (out_last),
        .fin       (out_final),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_north_buffer_feeder.sv
// Randomized bench for north_buffer_feeder: buffer contents and out_ready are random,
// expected beat stream is computed from pass/address arithmetic.
// Covers reset values, timing, multi-pass tags, stalls, zero passes, start while busy, mid-stream reset.
module tb_north_buffer_feeder;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] num_passes = '0;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_final;

    logic [W-1:0]  buf_mem [D];

    int n_vec = 0;
    int n_bad = 0;

    north_buffer_feeder #(
        .MODULE_WIDTH (W),
        .TOTAL_DEPTH  (D),
        .ADDR_WIDTH   (AW),
        .PASS_W       (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_passes (num_passes),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_dout    (rd_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_final  (out_final)
    );

    always #5 clk = ~clk;

    // North buffer model: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_dout <= buf_mem[rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
        check({tag, "_rd_en"},     rd_en,     1'b0);
        check({tag, "_rd_addr"},   rd_addr,   '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"},  out_data,  '0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_out_final"}, out_final, 1'b0);
    endtask

    // One command: passes full replays, out_ready high ready_pct% of cycles.
    // poke re-pulses start mid-stream; reset_beat>0 pulls rst_n after that many beats.
    task automatic run_stream(input int passes, input int ready_pct, input bit poke, input int reset_beat);
        int total;
        int n_reads = 0;
        int n_beats = 0;
        int first_rd = 0;
        int first_ov = 0;
        int final_k = 0;
        int done_k = 0;
        int n_done = 0;
        int a;
        bit did_reset = 1'b0;
        bit stall = 1'b0;
        logic [W-1:0] h_data = '0;
        logic [1:0]   h_tags = '0;
        int q_rd = 0;
        int q_ov = 0;
        int q_dn = 0;
        int q_bz = 0;

        total = passes * D;
        for (int i = 0; i < D; i++) buf_mem[i] = $urandom;

        @(negedge clk);
        num_passes = PW'(passes);
        start      = 1'b1;
        out_ready  = 1'b1;

        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke && k == 10) begin
                start      = 1'b1;
                num_passes = PW'(5);
            end
            if (poke && k == 11) start = 1'b0;
            out_ready = ($urandom_range(99) < ready_pct);
            #1;

            if (reset_beat > 0 && n_beats == reset_beat) begin
                rst_n = 1'b0;
                #1;
                check_quiet("mid_reset");
                did_reset = 1'b1;
                break;
            end

            if (rd_en) begin
                check("rd_addr", rd_addr, n_reads % D);
                if (first_rd == 0) first_rd = k;
                n_reads++;
            end
            if (out_valid && first_ov == 0) first_ov = k;
            if (stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, h_data);
                check("stall_tags", {out_last, out_final}, h_tags);
            end
            if (done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            check("busy", busy, (passes > 0) && (final_k == 0 || k <= final_k));

            if (out_valid && out_ready) begin
                if (n_beats < total) begin
                    a = n_beats % D;
                    check("beat_data",  out_data,  buf_mem[a]);
                    check("beat_last",  out_last,  a == D - 1);
                    check("beat_final", out_final, n_beats == total - 1);
                end else begin
                    check("extra_beat", n_beats, total);
                end
                if (out_final && final_k == 0) final_k = k;
                n_beats++;
            end
            stall  = out_valid && !out_ready;
            h_data = out_data;
            h_tags = {out_last, out_final};

            if (passes == 0 && k == 6) break;
            if (final_k > 0 && k == final_k + 3) break;
        end

        if (did_reset) begin
            out_ready = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                #1;
                if (rd_en)     q_rd++;
                if (out_valid) q_ov++;
                if (done)      q_dn++;
                if (busy)      q_bz++;
            end
            check("post_reset_reads", q_rd, 0);
            check("post_reset_beats", q_ov, 0);
            check("post_reset_done",  q_dn, 0);
            check("post_reset_busy",  q_bz, 0);
        end else begin
            check("beat_count", n_beats, total);
            check("read_count", n_reads, total);
            check("done_count", n_done, 1);
            check("first_rd_cycle", first_rd, (passes > 0) ? 1 : 0);
            check("first_valid_cycle", first_ov, (passes > 0) ? 3 : 0);
            check("done_cycle", done_k, (passes > 0) ? final_k + 1 : 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        run_stream(1, 100, 1'b0, 0);
        run_stream(3, 100, 1'b0, 0);
        run_stream(3, 50, 1'b0, 0);
        run_stream(2, 70, 1'b0, 0);
        run_stream(0, 100, 1'b0, 0);
        run_stream(2, 100, 1'b1, 0);
        run_stream(2, 100, 1'b0, D + 7);
        run_stream(1, 100, 1'b0, 0);
        run_stream(4, 30, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/north_buffer_feeder.md
NORTH_BUFFER_FEEDER -- requirements
Module: north_buffer_feeder

Interface
REQ-001 SHALL have parameter MODULE_WIDTH, default 32, width of one north-buffer word.
REQ-002 SHALL have parameter TOTAL_DEPTH, default 16, number of words per pass (COL_X).
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(TOTAL_DEPTH), buffer address width.
REQ-004 SHALL have parameter PASS_W, default 8, width of pass count.
REQ-005 SHALL have ports: clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: start  input  1  one-cycle request to begin streaming; ignored while busy.
REQ-008 SHALL have ports: num_passes  input  PASS_W  full-matrix replays, sampled with start.
REQ-009 SHALL have ports: busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse after the final beat is accepted.
REQ-011 SHALL have ports: rd_en  output  1  read strobe to north buffer port B.
REQ-012 SHALL have ports: rd_addr  output  ADDR_WIDTH  read address to north buffer.
REQ-013 SHALL have ports: rd_dout  input  MODULE_WIDTH  buffer data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have ports: out_valid / out_ready  output / input  1  downstream handshake; beat transfers when both high.
REQ-015 SHALL have ports: out_data  output  MODULE_WIDTH  streamed word.
REQ-016 SHALL have ports: out_last  output  1  marks word at address TOTAL_DEPTH-1 (end of pass).
REQ-017 SHALL have ports: out_final  output  1  marks last word of last pass.

Function
REQ-018 SHALL implement states IDLE, STREAM, DRAIN; IDLE->STREAM on start with num_passes>0; STREAM->DRAIN after last read issued; DRAIN->IDLE when final beat accepted.
REQ-019 SHALL, on start with num_passes==0, issue no reads, stay IDLE, pulse done next cycle.
REQ-020 SHALL issue reads in address order 0..TOTAL_DEPTH-1, wrapping to 0 for each subsequent pass.
REQ-021 SHALL hold a 2-entry output FIFO; read issued only when fifo_count + inflight - pop_this_cycle < 2, so no word is ever dropped.
REQ-022 SHALL capture rd_dout into FIFO on the edge ending the cycle after rd_en; out_valid rises the following cycle.
REQ-023 SHALL give latency: start sampled edge T0, first rd_en in T1, first out_valid in T3.
REQ-024 SHALL sustain one beat per cycle while out_ready stays high.
REQ-025 SHALL hold out_data, out_last, out_final stable while out_valid high and out_ready low.
REQ-026 SHALL carry last/final tags alongside each FIFO entry, derived at read-issue time.
REQ-027 SHALL assert done for exactly one cycle, cycle after final transfer; busy falls same cycle.
REQ-028 SHALL keep rd_en low in IDLE and DRAIN.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state IDLE, counters zero, FIFO empty, inflight cleared.
REQ-030 SHALL reset outputs busy, done, rd_en, out_valid, out_last, out_final to 0; rd_addr and out_data to 0.
REQ-031 SHALL, on reset mid-stream, discard any in-flight read; no beat appears after rst_n deasserts until a new start.

Structure
REQ-032 SHALL place the feeder state enum typedef in top_pkg.
REQ-033 SHALL use one sub-module, fifo2_tagged, a 2-entry FIFO carrying data plus last/final tags.

Verification
REQ-034 SHALL verify TOTAL_DEPTH=16, num_passes=1, out_ready=1 -> addresses 0..15, out_valid from T3, 16 contiguous beats, out_last and out_final on beat 16, done next cycle.
REQ-035 SHALL verify num_passes=3 -> 48 beats, out_last on beats 16/32/48, out_final only on 48, address wraps 15->0.
REQ-036 SHALL verify out_ready toggled pseudo-randomly -> data order matches buffer contents, no loss or duplication, outputs stable during stalls.
REQ-037 SHALL verify num_passes=0 -> no rd_en, done one cycle after start, busy never high.
REQ-038 SHALL verify rst_n low at beat 7 of pass 2 -> outputs zero immediately, no beats after release, fresh start streams from address 0.
REQ-039 SHALL verify start pulsed while busy -> ignored, beat count unchanged.
